// File: rtl/vga_frame_capture.sv
// Frames the MASTER pixel stream on v_sync and writes each active pixel's {R,G,B} to a frame-buffer port.
// Pixel-to-write latency is two cycles; no backpressure, every stream cycle is consumed as it arrives.
module vga_frame_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter bit SYNC_POL = 1'b0,
    parameter int ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              Mreset,
    input  logic              cap_en,
    input  logic              clr_err,
    input  logic [11:0]       RGBA,
    input  logic              h_sync,
    input  logic              v_sync,
    input  logic [9:0]        OX,
    input  logic [8:0]        OY,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [2:0]        wr_data,
    output logic              frame_done,
    output logic [ADDR_W-1:0] frame_lit,
    output logic [8:0]        frame_lines,
    output logic              coord_err,
    output logic              busy
);
    typedef enum logic [1:0] {SYNC_WAIT = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2} state_t;

    state_t            state_q;
    logic              cap_en_q, clr_err_q, hs_q, hs_prev_q, vs_q, vs_prev_q;
    logic [2:0]        col_q;
    logic [9:0]        ox_q;
    logic [8:0]        oy_q;
    logic              wr_en_q, frame_done_q, coord_err_q, busy_q, have_prev_q;
    logic [ADDR_W-1:0] wr_addr_q, frame_lit_q, lit_cnt_q;
    logic [2:0]        wr_data_q;
    logic [8:0]        frame_lines_q, line_cnt_q, prev_oy_q;

    logic              vs_act, vs_edge, vs_end, hs_edge, pix_vld, coord_set;
    logic [ADDR_W-1:0] pix_addr, lit_cnt_d;
    logic [8:0]        line_cnt_d;
    logic              unused_rgba;

    assign unused_rgba = ^{RGBA[11:9], RGBA[7:5], RGBA[3:1]};

    assign vs_act  = (vs_q == SYNC_POL);
    assign vs_edge = vs_act && (vs_prev_q != SYNC_POL);
    assign vs_end  = !vs_act && (vs_prev_q == SYNC_POL);
    assign hs_edge = (hs_q == SYNC_POL) && (hs_prev_q != SYNC_POL);

    // A pixel registered alongside a v_sync assertion is never valid because vs_act masks it.
    assign pix_vld   = (state_q == CAPTURE) && (32'(ox_q) < H_ACTIVE) &&
                       (32'(oy_q) < V_ACTIVE) && !vs_act;
    assign pix_addr  = ADDR_W'(oy_q) * ADDR_W'(H_ACTIVE) + ADDR_W'(ox_q);
    assign coord_set = pix_vld && have_prev_q && (oy_q < prev_oy_q);

    assign lit_cnt_d  = (pix_vld && (col_q != 3'd0) && !(&lit_cnt_q)) ?
                        lit_cnt_q + ADDR_W'(1) : lit_cnt_q;
    assign line_cnt_d = (hs_edge && !(&line_cnt_q)) ? line_cnt_q + 9'd1 : line_cnt_q;

    always_ff @(posedge clk) begin
        if (Mreset) begin
            state_q       <= SYNC_WAIT;
            cap_en_q      <= 1'b0;
            clr_err_q     <= 1'b0;
            hs_q          <= ~SYNC_POL;
            hs_prev_q     <= ~SYNC_POL;
            vs_q          <= ~SYNC_POL;
            vs_prev_q     <= ~SYNC_POL;
            col_q         <= '0;
            ox_q          <= '0;
            oy_q          <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_done_q  <= 1'b0;
            frame_lit_q   <= '0;
            frame_lines_q <= '0;
            coord_err_q   <= 1'b0;
            busy_q        <= 1'b0;
            lit_cnt_q     <= '0;
            line_cnt_q    <= '0;
            prev_oy_q     <= '0;
            have_prev_q   <= 1'b0;
        end else begin
            cap_en_q     <= cap_en;
            clr_err_q    <= clr_err;
            hs_q         <= h_sync;
            hs_prev_q    <= hs_q;
            vs_q         <= v_sync;
            vs_prev_q    <= vs_q;
            col_q        <= {RGBA[0], RGBA[4], RGBA[8]};
            ox_q         <= OX;
            oy_q         <= OY;

            wr_en_q      <= pix_vld;
            frame_done_q <= 1'b0;
            if (pix_vld) begin
                wr_addr_q <= pix_addr;
                wr_data_q <= col_q;
            end

            if (coord_set) begin
                coord_err_q <= 1'b1;
            end else if (clr_err_q) begin
                coord_err_q <= 1'b0;
            end

            case (state_q)
                SYNC_WAIT: begin
                    if (vs_edge) state_q <= ARMED;
                end
                ARMED: begin
                    if (vs_end && cap_en_q) begin
                        state_q     <= CAPTURE;
                        busy_q      <= 1'b1;
                        lit_cnt_q   <= '0;
                        line_cnt_q  <= '0;
                        have_prev_q <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (vs_edge) begin
                        state_q       <= ARMED;
                        busy_q        <= 1'b0;
                        frame_done_q  <= 1'b1;
                        frame_lit_q   <= lit_cnt_q;
                        frame_lines_q <= line_cnt_q;
                    end else begin
                        lit_cnt_q  <= lit_cnt_d;
                        line_cnt_q <= line_cnt_d;
                        if (pix_vld) begin
                            prev_oy_q   <= oy_q;
                            have_prev_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= SYNC_WAIT;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign frame_done  = frame_done_q;
    assign frame_lit   = frame_lit_q;
    assign frame_lines = frame_lines_q;
    assign coord_err   = coord_err_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_vga_frame_capture.sv
// Bench for vga_frame_capture: directed frame table, corner-case sequences and a random stream
// checked every cycle against a frame-level reference model.
module tb_vga_frame_capture;
    localparam int H  = 640;
    localparam int V  = 480;
    localparam int AW = 19;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          Mreset, cap_en, clr_err, h_sync, v_sync;
    logic [11:0]   RGBA;
    logic [9:0]    OX;
    logic [8:0]    OY;
    logic          wr_en, frame_done, coord_err, busy;
    logic [AW-1:0] wr_addr, frame_lit;
    logic [2:0]    wr_data;
    logic [8:0]    frame_lines;

    vga_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SYNC_POL(1'b0), .ADDR_W(AW)) dut (
        .clk(clk), .Mreset(Mreset), .cap_en(cap_en), .clr_err(clr_err), .RGBA(RGBA),
        .h_sync(h_sync), .v_sync(v_sync), .OX(OX), .OY(OY), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .frame_done(frame_done), .frame_lit(frame_lit),
        .frame_lines(frame_lines), .coord_err(coord_err), .busy(busy)
    );

    typedef struct {
        logic          wr_en;
        logic [AW-1:0] wr_addr;
        logic [2:0]    wr_data;
        logic          frame_done;
        logic [AW-1:0] frame_lit;
        logic [8:0]    frame_lines;
        logic          coord_err;
        logic          busy;
    } exp_t;

    typedef struct {
        int         ox;
        int         oy;
        logic [2:0] rgb;
        int         addr;
        int         lit;
    } vec_t;

    exp_t exp_q[$];
    exp_t m_out;
    int   m_mode, m_lit, m_lines, m_prev_oy;
    bit   m_prev_vs, m_prev_hs, m_have_prev;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    int wr_cnt, fd_cnt, wr_cyc, pix_cyc;
    logic [AW-1:0] last_addr, last_lit;
    logic [2:0]    last_data;
    logic [8:0]    last_lines;

    logic          st_rst, st_cap, st_clr, st_hs, st_vs;
    logic [9:0]    st_ox;
    logic [8:0]    st_oy;
    logic [11:0]   st_rgba;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc_n);
        end
    endtask

    function automatic exp_t zero_out();
        exp_t z;
        z.wr_en = 1'b0; z.wr_addr = '0; z.wr_data = '0; z.frame_done = 1'b0;
        z.frame_lit = '0; z.frame_lines = '0; z.coord_err = 1'b0; z.busy = 1'b0;
        return z;
    endfunction

    function automatic logic [11:0] to_rgba(input logic [2:0] rgb);
        logic [11:0] r;
        r = 12'($urandom) & 12'hEEE;
        r[0] = rgb[2];
        r[4] = rgb[1];
        r[8] = rgb[0];
        return r;
    endfunction

    // Reference: what the outputs must show two cycles after the inputs currently applied.
    task automatic model_step();
        exp_t e;
        bit vsa, hsa, vse, vsn, hse, vld;
        logic [2:0] col;
        if (Mreset) begin
            if (exp_q.size() > 0) exp_q[$] = zero_out();
            exp_q.push_back(zero_out());
            m_out = zero_out();
            m_mode = 0; m_lit = 0; m_lines = 0; m_prev_oy = 0;
            m_prev_vs = 1'b0; m_prev_hs = 1'b0; m_have_prev = 1'b0;
            return;
        end
        vsa = (v_sync == 1'b0);
        hsa = (h_sync == 1'b0);
        vse = vsa && !m_prev_vs;
        vsn = !vsa && m_prev_vs;
        hse = hsa && !m_prev_hs;
        m_prev_vs = vsa;
        m_prev_hs = hsa;
        e = m_out;
        e.wr_en = 1'b0;
        e.frame_done = 1'b0;
        col = {RGBA[0], RGBA[4], RGBA[8]};
        vld = (m_mode == 2) && (int'(OX) < H) && (int'(OY) < V) && !vsa;
        if (vld) begin
            e.wr_en = 1'b1;
            e.wr_addr = AW'(int'(OY) * H + int'(OX));
            e.wr_data = col;
            if (col != 3'd0 && m_lit < (1 << AW) - 1) m_lit++;
        end
        if (vld && m_have_prev && int'(OY) < m_prev_oy) e.coord_err = 1'b1;
        else if (clr_err) e.coord_err = 1'b0;
        if (vld) begin
            m_prev_oy = int'(OY);
            m_have_prev = 1'b1;
        end
        if (m_mode == 0 && vse) begin
            m_mode = 1;
        end else if (m_mode == 1 && vsn && cap_en) begin
            m_mode = 2; m_lit = 0; m_lines = 0; m_have_prev = 1'b0;
        end else if (m_mode == 2 && vse) begin
            m_mode = 1;
            e.frame_done = 1'b1;
            e.frame_lit = AW'(m_lit);
            e.frame_lines = 9'(m_lines);
        end else if (m_mode == 2 && hse && m_lines < 511) begin
            m_lines++;
        end
        e.busy = (m_mode == 2);
        m_out = e;
        exp_q.push_back(e);
    endtask

    task automatic cyc();
        exp_t e;
        @(posedge clk);
        #1;
        cyc_n++;
        Mreset = st_rst; cap_en = st_cap; clr_err = st_clr; h_sync = st_hs; v_sync = st_vs;
        OX = st_ox; OY = st_oy; RGBA = st_rgba;
        model_step();
        @(negedge clk);
        if (exp_q.size() == 3) begin
            e = exp_q.pop_front();
            chk("wr_en", 64'(wr_en), 64'(e.wr_en));
            chk("wr_addr", 64'(wr_addr), 64'(e.wr_addr));
            chk("wr_data", 64'(wr_data), 64'(e.wr_data));
            chk("frame_done", 64'(frame_done), 64'(e.frame_done));
            chk("frame_lit", 64'(frame_lit), 64'(e.frame_lit));
            chk("frame_lines", 64'(frame_lines), 64'(e.frame_lines));
            chk("coord_err", 64'(coord_err), 64'(e.coord_err));
            chk("busy", 64'(busy), 64'(e.busy));
        end
        if (wr_en === 1'b1) begin
            wr_cnt++; wr_cyc = cyc_n; last_addr = wr_addr; last_data = wr_data;
        end
        if (frame_done === 1'b1) begin
            fd_cnt++; last_lit = frame_lit; last_lines = frame_lines;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic vs_pulse(input logic cap);
        st_hs = 1'b1; st_ox = 10'd700;
        st_vs = 1'b0; cyc(); cyc();
        st_vs = 1'b1; st_cap = cap; cyc();
    endtask

    task automatic pixel(input int ox, input int oy, input logic [2:0] rgb);
        st_ox = 10'(ox); st_oy = 9'(oy); st_rgba = to_rgba(rgb);
        cyc();
        pix_cyc = cyc_n;
        st_ox = 10'd700; st_rgba = 12'h000;
    endtask

    initial begin
        vec_t tbl[5];
        int yb;
        tbl[0] = '{ox: 3,   oy: 2,   rgb: 3'b101, addr: 1283,   lit: 1};
        tbl[1] = '{ox: 0,   oy: 0,   rgb: 3'b000, addr: 0,      lit: 0};
        tbl[2] = '{ox: 639, oy: 479, rgb: 3'b111, addr: 307199, lit: 1};
        tbl[3] = '{ox: 639, oy: 0,   rgb: 3'b010, addr: 639,    lit: 1};
        tbl[4] = '{ox: 0,   oy: 1,   rgb: 3'b001, addr: 640,    lit: 1};

        st_cap = 1'b1; st_clr = 1'b0; st_hs = 1'b1; st_vs = 1'b1;
        st_ox = 10'd700; st_oy = 9'd0; st_rgba = 12'h000;
        wr_cnt = 0; fd_cnt = 0; wr_cyc = 0; pix_cyc = 0;

        // Reset held two cycles under an active, toggling stream.
        st_rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            st_vs = 1'($urandom); st_hs = 1'($urandom);
            st_ox = 10'($urandom_range(0, 639)); st_oy = 9'($urandom_range(0, 479));
            st_rgba = 12'($urandom);
            cyc();
        end
        st_rst = 1'b0; st_vs = 1'b1; st_hs = 1'b1; st_ox = 10'd700; st_rgba = 12'h000;
        wr_cnt = 0;
        idle(3);
        chk("rst_no_write", 64'(wr_cnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_frame_lit", 64'(frame_lit), 64'd0);
        chk("rst_coord_err", 64'(coord_err), 64'd0);

        // Single-pixel frames from the table.
        for (int i = 0; i < 5; i++) begin
            vs_pulse(1'b1);
            idle(2);
            wr_cnt = 0; fd_cnt = 0;
            pixel(tbl[i].ox, tbl[i].oy, tbl[i].rgb);
            idle(3);
            vs_pulse(1'b1);
            idle(3);
            chk("tbl_wr_cnt", 64'(wr_cnt), 64'd1);
            chk("tbl_addr", 64'(last_addr), 64'(tbl[i].addr));
            chk("tbl_data", 64'(last_data), 64'(tbl[i].rgb));
            chk("tbl_latency", 64'(wr_cyc - pix_cyc), 64'd2);
            chk("tbl_frame_done", 64'(fd_cnt), 64'd1);
            chk("tbl_frame_lit", 64'(last_lit), 64'(tbl[i].lit));
        end

        // Capture disabled at frame start: nothing written, no frame_done; re-enabled next frame.
        vs_pulse(1'b0);
        idle(3);
        wr_cnt = 0; fd_cnt = 0;
        pixel(5, 5, 3'b111);
        idle(3);
        vs_pulse(1'b1);
        idle(3);
        chk("dis_wr_cnt", 64'(wr_cnt), 64'd0);
        chk("dis_frame_done", 64'(fd_cnt), 64'd0);
        chk("reen_busy", 64'(busy), 64'd1);
        pixel(1, 0, 3'b001);
        idle(2);
        vs_pulse(1'b1);
        idle(3);
        chk("reen_wr_cnt", 64'(wr_cnt), 64'd1);
        chk("reen_frame_done", 64'(fd_cnt), 64'd1);

        // 480 lines of black pixels, then a frame with more than 511 h_sync pulses.
        for (int l = 0; l < 480; l++) begin
            st_hs = 1'b0; st_oy = 9'(l); cyc();
            st_hs = 1'b1; st_ox = 10'(l % H); st_rgba = 12'($urandom) & 12'hEEE; cyc();
            st_ox = 10'd700;
        end
        idle(2);
        fd_cnt = 0;
        vs_pulse(1'b1);
        idle(3);
        chk("lines480_done", 64'(fd_cnt), 64'd1);
        chk("lines480", 64'(last_lines), 64'd480);
        chk("lines480_lit", 64'(last_lit), 64'd0);
        for (int l = 0; l < 515; l++) begin
            st_hs = 1'b0; cyc();
            st_hs = 1'b1; cyc();
        end
        idle(2);
        vs_pulse(1'b1);
        idle(3);
        chk("lines_sat", 64'(last_lines), 64'd511);

        // OY going backwards sets a sticky error; clr_err clears it; set beats clear.
        idle(2);
        pixel(0, 10, 3'b001);
        pixel(0, 9, 3'b001);
        idle(3);
        chk("coord_set", 64'(coord_err), 64'd1);
        vs_pulse(1'b1);
        idle(3);
        chk("coord_sticky", 64'(coord_err), 64'd1);
        st_clr = 1'b1; cyc(); st_clr = 1'b0;
        idle(3);
        chk("coord_clr", 64'(coord_err), 64'd0);
        pixel(0, 3, 3'b010);
        idle(3);
        chk("coord_first_pix", 64'(coord_err), 64'd0);
        pixel(0, 5, 3'b001);
        st_clr = 1'b1;
        pixel(0, 4, 3'b001);
        st_clr = 1'b0;
        idle(3);
        chk("coord_set_wins", 64'(coord_err), 64'd1);
        st_clr = 1'b1; cyc(); st_clr = 1'b0;
        idle(3);

        // Reset in the middle of a capture after 50 lit pixels.
        vs_pulse(1'b1);
        idle(2);
        for (int i = 0; i < 50; i++) pixel(i, 7, 3'($urandom_range(1, 7)));
        idle(3);
        chk("mid_busy", 64'(busy), 64'd1);
        st_rst = 1'b1; cyc(); st_rst = 1'b0;
        idle(2);
        chk("mid_rst_lit", 64'(frame_lit), 64'd0);
        chk("mid_rst_lines", 64'(frame_lines), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        fd_cnt = 0;
        vs_pulse(1'b1);
        idle(3);
        chk("mid_rst_no_done", 64'(fd_cnt), 64'd0);

        // Random frames against the model.
        yb = 0;
        for (int f = 0; f < 8; f++) begin
            vs_pulse(1'($urandom_range(0, 3) != 0));
            for (int k = 0; k < 200; k++) begin
                if ($urandom_range(0, 9) == 0) yb = $urandom_range(0, 511);
                else if ($urandom_range(0, 3) == 0 && yb < 511) yb++;
                st_hs = 1'($urandom_range(0, 7) != 0);
                st_ox = 10'($urandom_range(0, 799));
                st_oy = 9'(yb);
                st_rgba = 12'($urandom);
                st_clr = 1'($urandom_range(0, 49) == 0);
                st_rst = 1'(f == 5 && k == 100);
                cyc();
            end
            st_clr = 1'b0; st_rst = 1'b0; st_rgba = 12'h000;
            st_hs = 1'b1; cyc();
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
